// File: rtl/conv_out_requant.sv
// Re-quantizes the signed convolution y stream to WIDTH bits (round, shift, ReLU, saturate)
// and buffers the results in a small FIFO feeding a valid/ready output with frame counting.
module conv_out_requant #(
   parameter int unsigned IN_WIDTH = 26,
   parameter int unsigned WIDTH    = 10,
   parameter int unsigned SHIFT    = 8,
   parameter int unsigned RELU     = 0,
   parameter int unsigned DEPTH    = 4,
   parameter int unsigned Y_COUNT  = 64
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic signed [IN_WIDTH-1:0] y_data,
   input  logic                       y_valid,
   output logic                       y_ready,
   output logic signed [WIDTH-1:0]    q_data,
   output logic                       q_valid,
   input  logic                       q_ready,
   output logic                       frame_done,
   output logic                       sat_seen
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam int unsigned FRM_W = (Y_COUNT > 1) ? $clog2(Y_COUNT) : 1;

   localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
   localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(Y_COUNT - 1);

   // Half-LSB rounding offset; zero when no shift is applied.
   localparam logic signed [IN_WIDTH:0] RND     = (IN_WIDTH+1)'((64'(1) << SHIFT) >> 1);
   localparam logic signed [IN_WIDTH:0] SAT_MAX = (IN_WIDTH+1)'((64'(1) << (WIDTH - 1)) - 64'(1));
   localparam logic signed [IN_WIDTH:0] SAT_MIN = ~SAT_MAX;

   logic signed [IN_WIDTH:0] y_ext, y_sum, y_shr, y_clip;
   logic        [WIDTH-1:0]  q_new;
   logic                     sat_hit;
   logic                     push, pop;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [FRM_W-1:0] frm_cnt_q, frm_cnt_d;
   logic             frame_done_q, frame_done_d;
   logic             sat_seen_q, sat_seen_d;

   assign y_ext = {y_data[IN_WIDTH-1], y_data};
   assign y_sum = y_ext + RND;
   assign y_shr = y_sum >>> SHIFT;

   always_comb begin
      y_clip  = y_shr;
      sat_hit = 1'b0;
      if ((RELU != 0) && y_shr[IN_WIDTH]) begin
         y_clip = '0;
      end
      if (y_clip > SAT_MAX) begin
         q_new   = SAT_MAX[WIDTH-1:0];
         sat_hit = 1'b1;
      end else if (y_clip < SAT_MIN) begin
         q_new   = SAT_MIN[WIDTH-1:0];
         sat_hit = 1'b1;
      end else begin
         q_new = y_clip[WIDTH-1:0];
      end
   end

   assign y_ready    = (count_q < DEPTH_C);
   assign q_valid    = (count_q != '0);
   assign q_data     = mem_q[rd_ptr_q];
   assign frame_done = frame_done_q;
   assign sat_seen   = sat_seen_q;

   assign push = y_valid && y_ready;
   assign pop  = q_valid && q_ready;

   always_comb begin
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      count_d      = count_q;
      frm_cnt_d    = frm_cnt_q;
      frame_done_d = 1'b0;
      sat_seen_d   = sat_seen_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (sat_hit) begin
            sat_seen_d = 1'b1;
         end
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
         if (frm_cnt_q == FRM_LAST) begin
            frm_cnt_d    = '0;
            frame_done_d = 1'b1;
         end else begin
            frm_cnt_d = frm_cnt_q + FRM_W'(1);
         end
      end
      if (push && !pop) begin
         count_d = count_q + CNT_W'(1);
      end else if (pop && !push) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         frm_cnt_q    <= '0;
         frame_done_q <= 1'b0;
         sat_seen_q   <= 1'b0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         frm_cnt_q    <= frm_cnt_d;
         frame_done_q <= frame_done_d;
         sat_seen_q   <= sat_seen_d;
      end
   end

   // Storage is cleared on reset so the idle head reads as zero.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (push) begin
         mem_q[wr_ptr_q] <= q_new;
      end
   end

endmodule
